routing_system_top: RTL and testbench



---
 rtl/routing_system_pkg.sv | 72 +++++++
 rtl/routing_lookup_port.sv | 120 ++++++++++++
 rtl/routing_system_top.sv | 257 +++++++++++++++++++++++++
 tb/tb_routing_system_top.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/routing_system_pkg.sv
`default_nettype none
// ============================================================================
// Module  : routing_system_pkg
// Purpose : Shared constants, table entry layouts and loader state encoding
//           for the routing table loader and its lookup ports.
// Rev     : 1.0  initial release
// ============================================================================
package routing_system_pkg;

    localparam int MAX_HOSTS        = 64;
    localparam int MAX_SWITCHES     = 16;
    localparam int ADDR_WIDTH       = 32;
    localparam int DATA_WIDTH       = 32;
    localparam int HOST_ENTRY_WIDTH = 256;
    localparam int PATH_ENTRY_WIDTH = 128;

    localparam int HOST_IDX_W = 6;
    localparam int SW_IDX_W   = 4;
    localparam int PATH_IDX_W = 2 * SW_IDX_W;
    localparam int WORD_BYTES = DATA_WIDTH / 8;

    // Words per entry in the configuration image
    localparam int HOST_WORDS = HOST_ENTRY_WIDTH / DATA_WIDTH;
    localparam int PATH_WORDS = PATH_ENTRY_WIDTH / DATA_WIDTH;

    // Word offsets inside a host entry
    localparam logic [2:0] HW_IP      = 3'd0;
    localparam logic [2:0] HW_SW_ID   = 3'd1;
    localparam logic [2:0] HW_SW_IP   = 3'd2;
    localparam logic [2:0] HW_PORT_QP = 3'd3;
    localparam logic [2:0] HW_MAC_LO  = 3'd4;
    localparam logic [2:0] HW_MAC_HI  = 3'd5;

    // Word offsets inside a path entry
    localparam logic [2:0] PW_META   = 3'd0;
    localparam logic [2:0] PW_OUT    = 3'd1;
    localparam logic [2:0] PW_NH_IP  = 3'd2;
    localparam logic [2:0] PW_NH_PQ  = 3'd3;

    typedef struct packed {
        logic [31:0] ip;
        logic [31:0] switch_id;
        logic [31:0] switch_ip;
        logic [15:0] port;
        logic [15:0] qp;
        logic [47:0] mac;
    } host_entry_t;

    typedef struct packed {
        logic        valid;
        logic [7:0]  next_hop;
        logic [15:0] distance;
        logic [15:0] out_port;
        logic [15:0] out_qp;
        logic [31:0] next_hop_ip;
        logic [15:0] next_hop_port;
        logic [15:0] next_hop_qp;
    } path_entry_t;

    localparam int HOST_BITS = $bits(host_entry_t);
    localparam int PATH_BITS = $bits(path_entry_t);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_HDR   = 3'd1,
        ST_RD_HOSTS = 3'd2,
        ST_RD_PATHS = 3'd3,
        ST_DONE     = 3'd4
    } load_state_t;

endpackage
`default_nettype wire

// File: rtl/routing_lookup_port.sv
`default_nettype none
// ============================================================================
// Module  : routing_lookup_port
// Purpose : One fully pipelined 3-stage lookup port.
//           S1 registers the request (dropped unless tables are ready),
//           S2 registers the table read and range check,
//           S3 formats and registers the response fields.
// Ports   : clk/rst, table status (ready, host/switch counts), request in,
//           table read port (index out, entry in), response out.
// Rev     : 1.0  initial release
// ============================================================================
module routing_lookup_port
    import routing_system_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  system_ready,
    input  logic [6:0]            host_cnt,
    input  logic [4:0]            sw_cnt,
    input  logic                  req_valid,
    input  logic                  req_type,
    input  logic [HOST_IDX_W-1:0] req_host_idx,
    input  logic [SW_IDX_W-1:0]   req_src_sw,
    input  logic [SW_IDX_W-1:0]   req_dst_sw,
    output logic [HOST_IDX_W-1:0] rd_host_idx,
    output logic [PATH_IDX_W-1:0] rd_path_idx,
    input  logic [HOST_BITS-1:0]  rd_host_entry,
    input  logic [PATH_BITS-1:0]  rd_path_entry,
    output logic                  resp_valid,
    output logic                  resp_type,
    output logic [31:0]           resp_host_ip,
    output logic [31:0]           resp_host_switch_id,
    output logic [31:0]           resp_host_switch_ip,
    output logic [15:0]           resp_host_port,
    output logic [15:0]           resp_host_qp,
    output logic [47:0]           resp_host_mac,
    output logic                  resp_path_valid,
    output logic [7:0]            resp_path_next_hop,
    output logic [15:0]           resp_path_out_port,
    output logic [15:0]           resp_path_out_qp,
    output logic [15:0]           resp_path_distance,
    output logic [31:0]           resp_path_next_hop_ip,
    output logic [15:0]           resp_path_next_hop_port,
    output logic [15:0]           resp_path_next_hop_qp
);

    logic                  r_s1_valid, r_s1_type;
    logic [HOST_IDX_W-1:0] r_s1_host_idx;
    logic [SW_IDX_W-1:0]   r_s1_src, r_s1_dst;
    logic                  r_s2_valid, r_s2_type, r_s2_in_range;
    host_entry_t           r_s2_host, r_resp_host;
    path_entry_t           r_s2_path, r_resp_path;
    logic                  r_resp_valid, r_resp_type;
    logic                  w_in_range;

    // Path table is indexed {src,dst}; stride is always MAX_SWITCHES
    assign rd_host_idx = r_s1_host_idx;
    assign rd_path_idx = {r_s1_src, r_s1_dst};

    assign w_in_range = r_s1_type ? (({1'b0, r_s1_src} < sw_cnt) && ({1'b0, r_s1_dst} < sw_cnt))
                                  : ({1'b0, r_s1_host_idx} < host_cnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_s1_type     <= 1'b0;
            r_s1_host_idx <= '0;
            r_s1_src      <= '0;
            r_s1_dst      <= '0;
            r_s2_valid    <= 1'b0;
            r_s2_type     <= 1'b0;
            r_s2_in_range <= 1'b0;
            r_s2_host     <= '0;
            r_s2_path     <= '0;
            r_resp_valid  <= 1'b0;
            r_resp_type   <= 1'b0;
            r_resp_host   <= '0;
            r_resp_path   <= '0;
        end else begin
            // S1: accept request only while the tables are valid
            r_s1_valid    <= req_valid && system_ready;
            r_s1_type     <= req_type;
            r_s1_host_idx <= req_host_idx;
            r_s1_src      <= req_src_sw;
            r_s1_dst      <= req_dst_sw;
            // S2: table read
            r_s2_valid    <= r_s1_valid;
            r_s2_type     <= r_s1_type;
            r_s2_in_range <= w_in_range;
            r_s2_host     <= host_entry_t'(rd_host_entry);
            r_s2_path     <= path_entry_t'(rd_path_entry);
            // S3: response; fields hold between responses
            r_resp_valid  <= r_s2_valid;
            if (r_s2_valid) begin
                r_resp_type <= r_s2_type;
                r_resp_host <= (!r_s2_type && r_s2_in_range) ? r_s2_host : '0;
                r_resp_path <= ( r_s2_type && r_s2_in_range) ? r_s2_path : '0;
            end
        end
    end

    assign resp_valid              = r_resp_valid;
    assign resp_type               = r_resp_type;
    assign resp_host_ip            = r_resp_host.ip;
    assign resp_host_switch_id     = r_resp_host.switch_id;
    assign resp_host_switch_ip     = r_resp_host.switch_ip;
    assign resp_host_port          = r_resp_host.port;
    assign resp_host_qp            = r_resp_host.qp;
    assign resp_host_mac           = r_resp_host.mac;
    assign resp_path_valid         = r_resp_path.valid;
    assign resp_path_next_hop      = r_resp_path.next_hop;
    assign resp_path_out_port      = r_resp_path.out_port;
    assign resp_path_out_qp        = r_resp_path.out_qp;
    assign resp_path_distance      = r_resp_path.distance;
    assign resp_path_next_hop_ip   = r_resp_path.next_hop_ip;
    assign resp_path_next_hop_port = r_resp_path.next_hop_port;
    assign resp_path_next_hop_qp   = r_resp_path.next_hop_qp;

endmodule
`default_nettype wire

// File: rtl/routing_system_top.sv
`default_nettype none
// ============================================================================
// Module  : routing_system_top
// Purpose : Loads host and path tables from a byte-addressed config memory
//           after start_init, then serves two independent lookup ports.
// Ports   : clk, rst (async, active-high); mem_addr/mem_data config memory;
//           start_init/init_busy/system_ready load control;
//           req_{a,b}_* lookup requests; resp_{a,b}_* lookup responses.
// Rev     : 1.0  initial release
// ============================================================================
module routing_system_top
    import routing_system_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  start_init,
    output logic                  init_busy,
    output logic                  system_ready,
    input  logic                  req_a_valid,
    input  logic                  req_a_type,
    input  logic [5:0]            req_a_host_idx,
    input  logic [3:0]            req_a_src_sw,
    input  logic [3:0]            req_a_dst_sw,
    output logic                  resp_a_valid,
    output logic                  resp_a_type,
    output logic [31:0]           resp_a_host_ip,
    output logic [31:0]           resp_a_host_switch_id,
    output logic [31:0]           resp_a_host_switch_ip,
    output logic [15:0]           resp_a_host_port,
    output logic [15:0]           resp_a_host_qp,
    output logic [47:0]           resp_a_host_mac,
    output logic                  resp_a_path_valid,
    output logic [7:0]            resp_a_path_next_hop,
    output logic [15:0]           resp_a_path_out_port,
    output logic [15:0]           resp_a_path_out_qp,
    output logic [15:0]           resp_a_path_distance,
    output logic [31:0]           resp_a_path_next_hop_ip,
    output logic [15:0]           resp_a_path_next_hop_port,
    output logic [15:0]           resp_a_path_next_hop_qp,
    input  logic                  req_b_valid,
    input  logic                  req_b_type,
    input  logic [5:0]            req_b_host_idx,
    input  logic [3:0]            req_b_src_sw,
    input  logic [3:0]            req_b_dst_sw,
    output logic                  resp_b_valid,
    output logic                  resp_b_type,
    output logic [31:0]           resp_b_host_ip,
    output logic [31:0]           resp_b_host_switch_id,
    output logic [31:0]           resp_b_host_switch_ip,
    output logic [15:0]           resp_b_host_port,
    output logic [15:0]           resp_b_host_qp,
    output logic [47:0]           resp_b_host_mac,
    output logic                  resp_b_path_valid,
    output logic [7:0]            resp_b_path_next_hop,
    output logic [15:0]           resp_b_path_out_port,
    output logic [15:0]           resp_b_path_out_qp,
    output logic [15:0]           resp_b_path_distance,
    output logic [31:0]           resp_b_path_next_hop_ip,
    output logic [15:0]           resp_b_path_next_hop_port,
    output logic [15:0]           resp_b_path_next_hop_qp
);

    load_state_t           r_state;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [6:0]            r_host_cnt;
    logic [4:0]            r_sw_cnt;
    logic [2:0]            r_word;
    logic [HOST_IDX_W-1:0] r_host_idx;
    logic [SW_IDX_W-1:0]   r_src, r_dst;
    logic                  r_busy, r_ready;
    logic [6:0]            w_host_cnt_clamp;
    logic [4:0]            w_sw_cnt_clamp;

    host_entry_t host_tab [MAX_HOSTS];
    path_entry_t path_tab [MAX_SWITCHES*MAX_SWITCHES];

    assign w_host_cnt_clamp = (mem_data > DATA_WIDTH'(MAX_HOSTS))    ? 7'(MAX_HOSTS)    : mem_data[6:0];
    assign w_sw_cnt_clamp   = (mem_data > DATA_WIDTH'(MAX_SWITCHES)) ? 5'(MAX_SWITCHES) : mem_data[4:0];

    // Image is contiguous, so the address simply advances one word per read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_host_cnt <= '0;
            r_sw_cnt   <= '0;
            r_word     <= '0;
            r_host_idx <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_init) begin
                        r_state <= ST_RD_HDR;
                        r_addr  <= '0;
                        r_word  <= '0;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                    end
                end
                ST_RD_HDR: begin
                    r_addr <= r_addr + ADDR_WIDTH'(WORD_BYTES);
                    if (r_word == 3'd0) begin
                        r_host_cnt <= w_host_cnt_clamp;
                        r_word     <= 3'd1;
                    end else begin
                        r_sw_cnt   <= w_sw_cnt_clamp;
                        r_word     <= '0;
                        r_host_idx <= '0;
                        r_src      <= '0;
                        r_dst      <= '0;
                        if (r_host_cnt != 7'd0) begin
                            r_state <= ST_RD_HOSTS;
                        end else if (w_sw_cnt_clamp != 5'd0) begin
                            r_state <= ST_RD_PATHS;
                        end else begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ST_RD_HOSTS: begin
                    r_addr <= r_addr + ADDR_WIDTH'(WORD_BYTES);
                    if (r_word == 3'(HOST_WORDS-1)) begin
                        r_word <= '0;
                        if ({1'b0, r_host_idx} == r_host_cnt - 7'd1) begin
                            if (r_sw_cnt != 5'd0) begin
                                r_state <= ST_RD_PATHS;
                            end else begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_ready <= 1'b1;
                            end
                        end else begin
                            r_host_idx <= r_host_idx + 1'b1;
                        end
                    end else begin
                        r_word <= r_word + 1'b1;
                    end
                end
                ST_RD_PATHS: begin
                    r_addr <= r_addr + ADDR_WIDTH'(WORD_BYTES);
                    if (r_word == 3'(PATH_WORDS-1)) begin
                        r_word <= '0;
                        if ({1'b0, r_dst} == r_sw_cnt - 5'd1) begin
                            r_dst <= '0;
                            if ({1'b0, r_src} == r_sw_cnt - 5'd1) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_ready <= 1'b1;
                            end else begin
                                r_src <= r_src + 1'b1;
                            end
                        end else begin
                            r_dst <= r_dst + 1'b1;
                        end
                    end else begin
                        r_word <= r_word + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Table storage: no reset needed, validity is governed by the counts
    always_ff @(posedge clk) begin
        if (r_state == ST_RD_HOSTS) begin
            case (r_word)
                HW_IP:      host_tab[r_host_idx].ip        <= mem_data;
                HW_SW_ID:   host_tab[r_host_idx].switch_id <= mem_data;
                HW_SW_IP:   host_tab[r_host_idx].switch_ip <= mem_data;
                HW_PORT_QP: begin
                    host_tab[r_host_idx].port <= mem_data[15:0];
                    host_tab[r_host_idx].qp   <= mem_data[31:16];
                end
                HW_MAC_LO:  host_tab[r_host_idx].mac[31:0]  <= mem_data;
                HW_MAC_HI:  host_tab[r_host_idx].mac[47:32] <= mem_data[15:0];
                default: ;
            endcase
        end else if (r_state == ST_RD_PATHS) begin
            case (r_word)
                PW_META: begin
                    path_tab[{r_src, r_dst}].valid    <= mem_data[0];
                    path_tab[{r_src, r_dst}].next_hop <= mem_data[15:8];
                    path_tab[{r_src, r_dst}].distance <= mem_data[31:16];
                end
                PW_OUT: begin
                    path_tab[{r_src, r_dst}].out_port <= mem_data[15:0];
                    path_tab[{r_src, r_dst}].out_qp   <= mem_data[31:16];
                end
                PW_NH_IP: path_tab[{r_src, r_dst}].next_hop_ip <= mem_data;
                PW_NH_PQ: begin
                    path_tab[{r_src, r_dst}].next_hop_port <= mem_data[15:0];
                    path_tab[{r_src, r_dst}].next_hop_qp   <= mem_data[31:16];
                end
                default: ;
            endcase
        end
    end

    assign mem_addr     = r_addr;
    assign init_busy    = r_busy;
    assign system_ready = r_ready;

    logic [HOST_IDX_W-1:0] w_rd_host_idx_a, w_rd_host_idx_b;
    logic [PATH_IDX_W-1:0] w_rd_path_idx_a, w_rd_path_idx_b;
    logic [HOST_BITS-1:0]  w_rd_host_a, w_rd_host_b;
    logic [PATH_BITS-1:0]  w_rd_path_a, w_rd_path_b;

    assign w_rd_host_a = host_tab[w_rd_host_idx_a];
    assign w_rd_host_b = host_tab[w_rd_host_idx_b];
    assign w_rd_path_a = path_tab[w_rd_path_idx_a];
    assign w_rd_path_b = path_tab[w_rd_path_idx_b];

    routing_lookup_port u_port_a (
        .clk(clk), .rst(rst), .system_ready(r_ready),
        .host_cnt(r_host_cnt), .sw_cnt(r_sw_cnt),
        .req_valid(req_a_valid), .req_type(req_a_type), .req_host_idx(req_a_host_idx),
        .req_src_sw(req_a_src_sw), .req_dst_sw(req_a_dst_sw),
        .rd_host_idx(w_rd_host_idx_a), .rd_path_idx(w_rd_path_idx_a),
        .rd_host_entry(w_rd_host_a), .rd_path_entry(w_rd_path_a),
        .resp_valid(resp_a_valid), .resp_type(resp_a_type),
        .resp_host_ip(resp_a_host_ip), .resp_host_switch_id(resp_a_host_switch_id),
        .resp_host_switch_ip(resp_a_host_switch_ip), .resp_host_port(resp_a_host_port),
        .resp_host_qp(resp_a_host_qp), .resp_host_mac(resp_a_host_mac),
        .resp_path_valid(resp_a_path_valid), .resp_path_next_hop(resp_a_path_next_hop),
        .resp_path_out_port(resp_a_path_out_port), .resp_path_out_qp(resp_a_path_out_qp),
        .resp_path_distance(resp_a_path_distance), .resp_path_next_hop_ip(resp_a_path_next_hop_ip),
        .resp_path_next_hop_port(resp_a_path_next_hop_port), .resp_path_next_hop_qp(resp_a_path_next_hop_qp)
    );

    routing_lookup_port u_port_b (
        .clk(clk), .rst(rst), .system_ready(r_ready),
        .host_cnt(r_host_cnt), .sw_cnt(r_sw_cnt),
        .req_valid(req_b_valid), .req_type(req_b_type), .req_host_idx(req_b_host_idx),
        .req_src_sw(req_b_src_sw), .req_dst_sw(req_b_dst_sw),
        .rd_host_idx(w_rd_host_idx_b), .rd_path_idx(w_rd_path_idx_b),
        .rd_host_entry(w_rd_host_b), .rd_path_entry(w_rd_path_b),
        .resp_valid(resp_b_valid), .resp_type(resp_b_type),
        .resp_host_ip(resp_b_host_ip), .resp_host_switch_id(resp_b_host_switch_id),
        .resp_host_switch_ip(resp_b_host_switch_ip), .resp_host_port(resp_b_host_port),
        .resp_host_qp(resp_b_host_qp), .resp_host_mac(resp_b_host_mac),
        .resp_path_valid(resp_b_path_valid), .resp_path_next_hop(resp_b_path_next_hop),
        .resp_path_out_port(resp_b_path_out_port), .resp_path_out_qp(resp_b_path_out_qp),
        .resp_path_distance(resp_b_path_distance), .resp_path_next_hop_ip(resp_b_path_next_hop_ip),
        .resp_path_next_hop_port(resp_b_path_next_hop_port), .resp_path_next_hop_qp(resp_b_path_next_hop_qp)
    );

endmodule
`default_nettype wire

// File: tb/tb_routing_system_top.sv
`default_nettype none
// ============================================================================
// Module  : tb_routing_system_top
// Purpose : Directed self-checking bench for routing_system_top with a
//           small config image (H=3 hosts, S=4 switches).
// Rev     : 1.0  initial release
// ============================================================================
module tb_routing_system_top;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        start_init, init_busy, system_ready;

    logic        req_a_valid, req_a_type, req_b_valid, req_b_type;
    logic [5:0]  req_a_host_idx, req_b_host_idx;
    logic [3:0]  req_a_src_sw, req_a_dst_sw, req_b_src_sw, req_b_dst_sw;

    logic        resp_a_valid, resp_a_type, resp_b_valid, resp_b_type;
    logic [31:0] resp_a_host_ip, resp_a_host_switch_id, resp_a_host_switch_ip;
    logic [31:0] resp_b_host_ip, resp_b_host_switch_id, resp_b_host_switch_ip;
    logic [15:0] resp_a_host_port, resp_a_host_qp, resp_b_host_port, resp_b_host_qp;
    logic [47:0] resp_a_host_mac, resp_b_host_mac;
    logic        resp_a_path_valid, resp_b_path_valid;
    logic [7:0]  resp_a_path_next_hop, resp_b_path_next_hop;
    logic [15:0] resp_a_path_out_port, resp_a_path_out_qp, resp_a_path_distance;
    logic [15:0] resp_b_path_out_port, resp_b_path_out_qp, resp_b_path_distance;
    logic [31:0] resp_a_path_next_hop_ip, resp_b_path_next_hop_ip;
    logic [15:0] resp_a_path_next_hop_port, resp_a_path_next_hop_qp;
    logic [15:0] resp_b_path_next_hop_port, resp_b_path_next_hop_qp;

    logic [31:0] mem [0:127];
    int checks   = 0;
    int failures = 0;
    int n, seen;
    logic busy_late;

    assign mem_data = (mem_addr < 32'd512) ? mem[mem_addr[8:2]] : 32'h0;

    always #5 clk = ~clk;

    routing_system_top dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data),
        .start_init(start_init), .init_busy(init_busy), .system_ready(system_ready),
        .req_a_valid(req_a_valid), .req_a_type(req_a_type), .req_a_host_idx(req_a_host_idx),
        .req_a_src_sw(req_a_src_sw), .req_a_dst_sw(req_a_dst_sw),
        .resp_a_valid(resp_a_valid), .resp_a_type(resp_a_type),
        .resp_a_host_ip(resp_a_host_ip), .resp_a_host_switch_id(resp_a_host_switch_id),
        .resp_a_host_switch_ip(resp_a_host_switch_ip), .resp_a_host_port(resp_a_host_port),
        .resp_a_host_qp(resp_a_host_qp), .resp_a_host_mac(resp_a_host_mac),
        .resp_a_path_valid(resp_a_path_valid), .resp_a_path_next_hop(resp_a_path_next_hop),
        .resp_a_path_out_port(resp_a_path_out_port), .resp_a_path_out_qp(resp_a_path_out_qp),
        .resp_a_path_distance(resp_a_path_distance), .resp_a_path_next_hop_ip(resp_a_path_next_hop_ip),
        .resp_a_path_next_hop_port(resp_a_path_next_hop_port), .resp_a_path_next_hop_qp(resp_a_path_next_hop_qp),
        .req_b_valid(req_b_valid), .req_b_type(req_b_type), .req_b_host_idx(req_b_host_idx),
        .req_b_src_sw(req_b_src_sw), .req_b_dst_sw(req_b_dst_sw),
        .resp_b_valid(resp_b_valid), .resp_b_type(resp_b_type),
        .resp_b_host_ip(resp_b_host_ip), .resp_b_host_switch_id(resp_b_host_switch_id),
        .resp_b_host_switch_ip(resp_b_host_switch_ip), .resp_b_host_port(resp_b_host_port),
        .resp_b_host_qp(resp_b_host_qp), .resp_b_host_mac(resp_b_host_mac),
        .resp_b_path_valid(resp_b_path_valid), .resp_b_path_next_hop(resp_b_path_next_hop),
        .resp_b_path_out_port(resp_b_path_out_port), .resp_b_path_out_qp(resp_b_path_out_qp),
        .resp_b_path_distance(resp_b_path_distance), .resp_b_path_next_hop_ip(resp_b_path_next_hop_ip),
        .resp_b_path_next_hop_port(resp_b_path_next_hop_port), .resp_b_path_next_hop_qp(resp_b_path_next_hop_qp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request per port for a single cycle; returns 1 ns after the sampling edge
    task automatic pulse(input logic va, input logic ta, input logic [5:0] ha,
                         input logic [3:0] sa, input logic [3:0] da,
                         input logic vb, input logic tyb, input logic [5:0] hb,
                         input logic [3:0] sb, input logic [3:0] db);
        @(negedge clk);
        req_a_valid = va; req_a_type = ta; req_a_host_idx = ha; req_a_src_sw = sa; req_a_dst_sw = da;
        req_b_valid = vb; req_b_type = tyb; req_b_host_idx = hb; req_b_src_sw = sb; req_b_dst_sw = db;
        @(posedge clk);
        #1;
        req_a_valid = 1'b0;
        req_b_valid = 1'b0;
    endtask

    task automatic wait_ready;
        n = 0;
        busy_late = 1'b0;
        while (!system_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 89) busy_late = init_busy;
        end
    endtask

    initial begin
        rst = 1'b1; start_init = 1'b0;
        req_a_valid = 1'b0; req_a_type = 1'b0; req_a_host_idx = '0; req_a_src_sw = '0; req_a_dst_sw = '0;
        req_b_valid = 1'b0; req_b_type = 1'b0; req_b_host_idx = '0; req_b_src_sw = '0; req_b_dst_sw = '0;

        // Image: H=3, S=4; hosts at word 2, paths at word 26
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0] = 32'd3;
        mem[1] = 32'd4;
        for (int h = 0; h < 3; h++) begin
            mem[2 + 8*h + 0] = 32'h0A000001 + h;
            mem[2 + 8*h + 1] = h + 1;
            mem[2 + 8*h + 2] = 32'h0A000000 + ((h + 1) << 8);
            mem[2 + 8*h + 3] = ((100 * (h + 1)) << 16) | (h + 1);
            mem[2 + 8*h + 4] = h + 1;
            mem[2 + 8*h + 5] = 32'hABCD0200;
            mem[2 + 8*h + 6] = 32'hFFFFFFFF;
            mem[2 + 8*h + 7] = 32'hFFFFFFFF;
        end
        for (int p = 0; p < 16; p++) begin
            mem[26 + 4*p + 0] = 32'h00FFFF00;
            mem[26 + 4*p + 1] = 32'h11112222;
            mem[26 + 4*p + 2] = 32'h33333333;
            mem[26 + 4*p + 3] = 32'h44445555;
        end
        // path 1->2 (index 6)
        mem[50] = 32'h00010201; mem[51] = 32'h00070003; mem[52] = 32'h0A000102; mem[53] = 32'h00090004;
        // path 3->1 (index 13)
        mem[78] = 32'h00020101; mem[79] = 32'h00050006; mem[80] = 32'h0A000101; mem[81] = 32'h000B000C;

        step(3);
        chk("rst_busy", init_busy, 1'b0);
        chk("rst_ready", system_ready, 1'b0);
        chk("rst_resp_a", resp_a_valid, 1'b0);
        chk("rst_resp_b", resp_b_valid, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        @(negedge clk) rst = 1'b0;

        // Requests before tables are loaded are dropped
        pulse(1, 0, 6'd0, 4'd0, 4'd0, 1, 1, 6'd0, 4'd1, 4'd2);
        seen = 0;
        repeat (5) begin
            if (resp_a_valid || resp_b_valid) seen++;
            step(1);
        end
        chk("drop_before_ready", seen, 0);

        // Load
        @(negedge clk) start_init = 1'b1;
        @(posedge clk); #1; start_init = 1'b0;
        chk("load_busy", init_busy, 1'b1);
        chk("load_not_ready", system_ready, 1'b0);
        wait_ready();
        chk("load_cycles", n, 90);
        chk("busy_before_done", busy_late, 1'b1);
        chk("busy_after_done", init_busy, 1'b0);

        // Host 0 on A, with latency checks
        pulse(1, 0, 6'd0, 4'd0, 4'd0, 0, 0, 6'd0, 4'd0, 4'd0);
        chk("h0_lat0", resp_a_valid, 1'b0);
        step(1);
        chk("h0_lat1", resp_a_valid, 1'b0);
        step(1);
        chk("h0_valid", resp_a_valid, 1'b1);
        chk("h0_type", resp_a_type, 1'b0);
        chk("h0_ip", resp_a_host_ip, 32'h0A000001);
        chk("h0_swid", resp_a_host_switch_id, 32'd1);
        chk("h0_swip", resp_a_host_switch_ip, 32'h0A000100);
        chk("h0_port", resp_a_host_port, 16'd1);
        chk("h0_qp", resp_a_host_qp, 16'd100);
        chk("h0_mac", resp_a_host_mac, 48'h020000000001);
        chk("h0_pathv", resp_a_path_valid, 1'b0);
        chk("h0_b_quiet", resp_b_valid, 1'b0);
        step(1);
        chk("h0_pulse_end", resp_a_valid, 1'b0);
        chk("h0_hold", resp_a_host_ip, 32'h0A000001);

        // Path 1->2 on A
        pulse(1, 1, 6'd0, 4'd1, 4'd2, 0, 0, 6'd0, 4'd0, 4'd0);
        step(2);
        chk("p12_valid", resp_a_valid, 1'b1);
        chk("p12_type", resp_a_type, 1'b1);
        chk("p12_pv", resp_a_path_valid, 1'b1);
        chk("p12_nh", resp_a_path_next_hop, 8'd2);
        chk("p12_dist", resp_a_path_distance, 16'd1);
        chk("p12_oport", resp_a_path_out_port, 16'd3);
        chk("p12_oqp", resp_a_path_out_qp, 16'd7);
        chk("p12_nhip", resp_a_path_next_hop_ip, 32'h0A000102);
        chk("p12_nhport", resp_a_path_next_hop_port, 16'd4);
        chk("p12_nhqp", resp_a_path_next_hop_qp, 16'd9);
        chk("p12_host0", resp_a_host_ip, 32'h0);

        // Concurrent: A host 1, B path 3->1
        pulse(1, 0, 6'd1, 4'd0, 4'd0, 1, 1, 6'd0, 4'd3, 4'd1);
        step(1);
        chk("cc_early_a", resp_a_valid, 1'b0);
        chk("cc_early_b", resp_b_valid, 1'b0);
        step(1);
        chk("cc_a_valid", resp_a_valid, 1'b1);
        chk("cc_b_valid", resp_b_valid, 1'b1);
        chk("cc_a_ip", resp_a_host_ip, 32'h0A000002);
        chk("cc_a_qp", resp_a_host_qp, 16'd200);
        chk("cc_a_mac", resp_a_host_mac, 48'h020000000002);
        chk("cc_a_pathnh", resp_a_path_next_hop, 8'd0);
        chk("cc_b_pv", resp_b_path_valid, 1'b1);
        chk("cc_b_nh", resp_b_path_next_hop, 8'd1);
        chk("cc_b_dist", resp_b_path_distance, 16'd2);
        chk("cc_b_oport", resp_b_path_out_port, 16'd6);
        chk("cc_b_nhip", resp_b_path_next_hop_ip, 32'h0A000101);
        chk("cc_b_nhqp", resp_b_path_next_hop_qp, 16'd11);

        // Back-to-back on A: host 0 then host 2
        @(negedge clk);
        req_a_valid = 1'b1; req_a_type = 1'b0; req_a_host_idx = 6'd0;
        @(posedge clk); #1;
        req_a_host_idx = 6'd2;
        @(posedge clk); #1;
        req_a_valid = 1'b0;
        step(1);
        chk("b2b_1_valid", resp_a_valid, 1'b1);
        chk("b2b_1_ip", resp_a_host_ip, 32'h0A000001);
        step(1);
        chk("b2b_2_valid", resp_a_valid, 1'b1);
        chk("b2b_2_ip", resp_a_host_ip, 32'h0A000003);
        chk("b2b_2_swid", resp_a_host_switch_id, 32'd3);

        // Same index on both ports
        pulse(1, 0, 6'd1, 4'd0, 4'd0, 1, 0, 6'd1, 4'd0, 4'd0);
        step(2);
        chk("same_a_ip", resp_a_host_ip, 32'h0A000002);
        chk("same_b_ip", resp_b_host_ip, 32'h0A000002);
        chk("same_b_valid", resp_b_valid, 1'b1);

        // Out of range: host 5 on A, path 5->1 on B
        pulse(1, 0, 6'd5, 4'd0, 4'd0, 1, 1, 6'd0, 4'd5, 4'd1);
        step(2);
        chk("oor_h_valid", resp_a_valid, 1'b1);
        chk("oor_h_ip", resp_a_host_ip, 32'h0);
        chk("oor_h_mac", resp_a_host_mac, 48'h0);
        chk("oor_p_valid", resp_b_valid, 1'b1);
        chk("oor_p_pv", resp_b_path_valid, 1'b0);
        chk("oor_p_nhip", resp_b_path_next_hop_ip, 32'h0);
        chk("oor_p_dist", resp_b_path_distance, 16'h0);
        chk("oor_b_host", resp_b_host_ip, 32'h0);

        // Path 0->0 in range but not a valid route
        pulse(0, 0, 6'd0, 4'd0, 4'd0, 1, 1, 6'd0, 4'd0, 4'd0);
        step(2);
        chk("p00_pv", resp_b_path_valid, 1'b0);
        chk("p00_nhip", resp_b_path_next_hop_ip, 32'h33333333);

        // Reset mid-lookup: no response, tables invalidated
        pulse(1, 0, 6'd0, 4'd0, 4'd0, 0, 0, 6'd0, 4'd0, 4'd0);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rl_ready", system_ready, 1'b0);
        chk("rl_ip", resp_a_host_ip, 32'h0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (4) begin
            step(1);
            if (resp_a_valid) seen++;
        end
        chk("rl_no_resp", seen, 0);

        // Reset mid-load, then a clean reload
        @(negedge clk) start_init = 1'b1;
        @(posedge clk); #1; start_init = 1'b0;
        step(20);
        chk("ml_busy", init_busy, 1'b1);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("ml_busy_clr", init_busy, 1'b0);
        chk("ml_ready_clr", system_ready, 1'b0);
        chk("ml_addr_clr", mem_addr, 32'h0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk) start_init = 1'b1;
        @(posedge clk); #1; start_init = 1'b0;
        wait_ready();
        chk("reload_cycles", n, 90);
        pulse(0, 0, 6'd0, 4'd0, 4'd0, 1, 0, 6'd2, 4'd0, 4'd0);
        step(2);
        chk("reload_valid", resp_b_valid, 1'b1);
        chk("reload_ip", resp_b_host_ip, 32'h0A000003);
        chk("reload_port", resp_b_host_port, 16'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
